// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU issue stage:
//   - ALU function codes driven on f_o
//   - RV32I opcode / funct3 / funct7 field values recognised by the decoder
//   - decoded_op_t, the bundle carried through the skid buffer
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    // ALU function codes
    localparam logic [5:0] F_NONE = 6'd0;
    localparam logic [5:0] F_LB   = 6'd10;
    localparam logic [5:0] F_LH   = 6'd11;
    localparam logic [5:0] F_LW   = 6'd12;
    localparam logic [5:0] F_LBU  = 6'd13;
    localparam logic [5:0] F_LHU  = 6'd14;
    localparam logic [5:0] F_SB   = 6'd15;
    localparam logic [5:0] F_SH   = 6'd16;
    localparam logic [5:0] F_SW   = 6'd17;
    localparam logic [5:0] F_ADDI = 6'd18;
    localparam logic [5:0] F_XORI = 6'd21;
    localparam logic [5:0] F_ORI  = 6'd22;
    localparam logic [5:0] F_ANDI = 6'd23;
    localparam logic [5:0] F_SLLI = 6'd24;
    localparam logic [5:0] F_SRLI = 6'd25;
    localparam logic [5:0] F_ADD  = 6'd27;
    localparam logic [5:0] F_SUB  = 6'd28;
    localparam logic [5:0] F_SLL  = 6'd29;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 values
    localparam logic [2:0] F3_000 = 3'b000;
    localparam logic [2:0] F3_001 = 3'b001;
    localparam logic [2:0] F3_010 = 3'b010;
    localparam logic [2:0] F3_100 = 3'b100;
    localparam logic [2:0] F3_101 = 3'b101;
    localparam logic [2:0] F3_110 = 3'b110;
    localparam logic [2:0] F3_111 = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [5:0]      f;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } decoded_op_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_if
// Bundles every non-clock/reset signal of the ALU issue stage.
//   slave  : the stage itself (consumes instructions, produces decoded ops)
//   master : the environment (fetch/regfile side and ALU side)
// Signals: in_valid_i/in_ready_o/instr_i (input handshake), flush_i,
// rs1/rs2 address and data, out_valid_o/out_ready_i (output handshake),
// f_o, op1_o, op2_o, store_data_o, rd_o, rd_we_o, illegal_o.
// -----------------------------------------------------------------------------
interface alu_issue_if;
    import alu_pkg::*;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic            flush_i;
    logic [4:0]      rs1_addr_o;
    logic [4:0]      rs2_addr_o;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [5:0]      f_o;
    logic [XLEN-1:0] op1_o;
    logic [XLEN-1:0] op2_o;
    logic [XLEN-1:0] store_data_o;
    logic [4:0]      rd_o;
    logic            rd_we_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, instr_i, flush_i, rs1_data_i, rs2_data_i, out_ready_i,
        output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
               f_o, op1_o, op2_o, store_data_o, rd_o, rd_we_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_i, flush_i, rs1_data_i, rs2_data_i, out_ready_i,
        input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
               f_o, op1_o, op2_o, store_data_o, rd_o, rd_we_o, illegal_o
    );

endinterface

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational RV32I subset decoder.
//   i_instr    : instruction word
//   i_rs1_data : register-file data for instr[19:15]
//   i_rs2_data : register-file data for instr[24:20]
//   o_dec      : decoded bundle (function code, operands, store data, rd, flags)
// Unsupported encodings produce illegal=1 with every data field zero; rd still
// reflects instr[11:7].
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output decoded_op_t     o_dec
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_shamt  = {{(XLEN-5){1'b0}}, i_instr[24:20]};

    logic            w_legal;
    logic            w_store;
    logic [5:0]      w_f;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        w_legal = 1'b0;
        w_store = 1'b0;
        w_f     = F_NONE;
        w_op1   = i_rs1_data;
        w_op2   = '0;
        unique case (w_opcode)
            OPC_LOAD: begin
                w_op2 = w_imm_i;
                case (w_funct3)
                    F3_000: begin w_f = F_LB;  w_legal = 1'b1; end
                    F3_001: begin w_f = F_LH;  w_legal = 1'b1; end
                    F3_010: begin w_f = F_LW;  w_legal = 1'b1; end
                    F3_100: begin w_f = F_LBU; w_legal = 1'b1; end
                    F3_101: begin w_f = F_LHU; w_legal = 1'b1; end
                    default: ;
                endcase
            end
            OPC_STORE: begin
                w_op2   = w_imm_s;
                w_store = 1'b1;
                case (w_funct3)
                    F3_000: begin w_f = F_SB; w_legal = 1'b1; end
                    F3_001: begin w_f = F_SH; w_legal = 1'b1; end
                    F3_010: begin w_f = F_SW; w_legal = 1'b1; end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                w_op2 = w_imm_i;
                case (w_funct3)
                    F3_000: begin w_f = F_ADDI; w_legal = 1'b1; end
                    F3_100: begin w_f = F_XORI; w_legal = 1'b1; end
                    F3_110: begin w_f = F_ORI;  w_legal = 1'b1; end
                    F3_111: begin w_f = F_ANDI; w_legal = 1'b1; end
                    // Shifts use only the 5-bit shamt; SRAI (funct7 0100000)
                    // is not supported and falls through as illegal.
                    F3_001: begin
                        w_op2   = w_shamt;
                        w_f     = F_SLLI;
                        w_legal = (w_funct7 == F7_BASE);
                    end
                    F3_101: begin
                        w_op2   = w_shamt;
                        w_f     = F_SRLI;
                        w_legal = (w_funct7 == F7_BASE);
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                w_op2 = i_rs2_data;
                if (w_funct3 == F3_000 && w_funct7 == F7_BASE) begin
                    w_f = F_ADD; w_legal = 1'b1;
                end else if (w_funct3 == F3_000 && w_funct7 == F7_ALT) begin
                    w_f = F_SUB; w_legal = 1'b1;
                end else if (w_funct3 == F3_001 && w_funct7 == F7_BASE) begin
                    w_f = F_SLL; w_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_dec.rd = i_instr[11:7];
        if (w_legal) begin
            o_dec.f          = w_f;
            o_dec.op1        = w_op1;
            o_dec.op2        = w_op2;
            o_dec.store_data = w_store ? i_rs2_data : '0;
            o_dec.rd_we      = !w_store && (i_instr[11:7] != 5'd0);
            o_dec.illegal    = 1'b0;
        end else begin
            o_dec.f          = F_NONE;
            o_dec.op1        = '0;
            o_dec.op2        = '0;
            o_dec.store_data = '0;
            o_dec.rd_we      = 1'b0;
            o_dec.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Decodes one RV32I instruction per cycle and presents the ALU op through a
// 2-entry skid buffer (MAIN drives the outputs, SKID absorbs one extra
// instruction when the ALU stalls).
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : alu_issue_if.slave (handshakes, instruction, regfile, decoded op)
// in_ready_o comes straight from a flop (!SKID.valid), so the upstream ready
// path never depends on out_ready_i.
// -----------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    alu_issue_if.slave  bus
);

    decoded_op_t w_dec;
    decoded_op_t r_main;
    decoded_op_t r_skid;
    logic        r_main_valid;
    logic        r_skid_valid;
    logic        w_in_fire;
    logic        w_out_fire;

    assign bus.rs1_addr_o = bus.instr_i[19:15];
    assign bus.rs2_addr_o = bus.instr_i[24:20];

    alu_op_decode u_decode (
        .i_instr    (bus.instr_i),
        .i_rs1_data (bus.rs1_data_i),
        .i_rs2_data (bus.rs2_data_i),
        .o_dec      (w_dec)
    );

    assign bus.in_ready_o = !r_skid_valid;
    assign w_in_fire      = bus.in_valid_i && !r_skid_valid;
    assign w_out_fire     = r_main_valid && bus.out_ready_i;

    // in_fire implies SKID is empty, so a new instruction never has to be
    // written while SKID is being promoted into MAIN.
    always_ff @(posedge clk_i) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (bus.flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_out_fire) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.out_valid_o  = r_main_valid;
    assign bus.f_o          = r_main.f;
    assign bus.op1_o        = r_main.op1;
    assign bus.op2_o        = r_main.op2;
    assign bus.store_data_o = r_main.store_data;
    assign bus.rd_o         = r_main.rd;
    assign bus.rd_we_o      = r_main.rd_we;
    assign bus.illegal_o    = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed, table-driven bench for alu_issue_stage plus hand-written
// backpressure, flush and mid-operation reset sequences.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if u_if ();

    alu_issue_stage u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  f;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rd_we;
        logic        ill;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, ".valid"},   32'(u_if.out_valid_o),  32'd1);
        check({tag, ".f"},       32'(u_if.f_o),          32'(v.f));
        check({tag, ".op1"},     u_if.op1_o,             v.op1);
        check({tag, ".op2"},     u_if.op2_o,             v.op2);
        check({tag, ".sd"},      u_if.store_data_o,      v.sd);
        check({tag, ".rd"},      32'(u_if.rd_o),         32'(v.rd));
        check({tag, ".rd_we"},   32'(u_if.rd_we_o),      32'(v.rd_we));
        check({tag, ".illegal"}, 32'(u_if.illegal_o),    32'(v.ill));
    endtask

    task automatic drive(input vec_t v);
        u_if.in_valid_i = 1'b1;
        u_if.instr_i    = v.instr;
        u_if.rs1_data_i = v.rs1;
        u_if.rs2_data_i = v.rs2;
    endtask

    task automatic idle_in();
        u_if.in_valid_i = 1'b0;
        u_if.instr_i    = 32'h0;
        u_if.rs1_data_i = 32'h0;
        u_if.rs2_data_i = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".out_valid"}, 32'(u_if.out_valid_o), 32'd0);
        check({tag, ".in_ready"},  32'(u_if.in_ready_o),  32'd1);
    endtask

    initial begin
        //        name      instr          rs1           rs2           f   op1           op2           sd            rd  we ill
        vecs[0]  = '{"addi",  32'hFFF08293, 32'h10,       32'h0,        18, 32'h10,       32'hFFFFFFFF, 32'h0,        5,  1, 0};
        vecs[1]  = '{"sub",   32'h402081B3, 32'h7,        32'h3,        28, 32'h7,        32'h3,        32'h0,        3,  1, 0};
        vecs[2]  = '{"sw",    32'h0020A423, 32'h100,      32'hDEADBEEF, 17, 32'h100,      32'h8,        32'hDEADBEEF, 8,  0, 0};
        vecs[3]  = '{"srai",  32'h4010D093, 32'h55,       32'h66,       0,  32'h0,        32'h0,        32'h0,        1,  0, 1};
        vecs[4]  = '{"lw",    32'hFFC12303, 32'h1000,     32'h0,        12, 32'h1000,     32'hFFFFFFFC, 32'h0,        6,  1, 0};
        vecs[5]  = '{"lbu_x0",32'h0050C003, 32'h20,       32'h0,        13, 32'h20,       32'h5,        32'h0,        0,  0, 0};
        vecs[6]  = '{"slli",  32'h01F09393, 32'h1,        32'h0,        24, 32'h1,        32'd31,       32'h0,        7,  1, 0};
        vecs[7]  = '{"slli_f7",32'h41F09393,32'h1,        32'h0,        0,  32'h0,        32'h0,        32'h0,        7,  0, 1};
        vecs[8]  = '{"andi",  32'h7FF1F493, 32'hFFFF0F0F, 32'h0,        23, 32'hFFFF0F0F, 32'h7FF,      32'h0,        9,  1, 0};
        vecs[9]  = '{"sll",   32'h00521533, 32'hAA,       32'h4,        29, 32'hAA,       32'h4,        32'h0,        10, 1, 0};
        vecs[10] = '{"or_ill",32'h00526533, 32'hAA,       32'h4,        0,  32'h0,        32'h0,        32'h0,        10, 0, 1};
        vecs[11] = '{"lui",   32'h12345037, 32'h1,        32'h2,        0,  32'h0,        32'h0,        32'h0,        0,  0, 1};
        vecs[12] = '{"ld_f3", 32'h0000B183, 32'h9,        32'h0,        0,  32'h0,        32'h0,        32'h0,        3,  0, 1};
        vecs[13] = '{"sb",    32'hFE208FA3, 32'h4,        32'h55,       15, 32'h4,        32'hFFFFFFFF, 32'h55,       31, 0, 0};
        vecs[14] = '{"add",   32'h002081B3, 32'h7,        32'h3,        27, 32'h7,        32'h3,        32'h0,        3,  1, 0};
        vecs[15] = '{"xori",  32'hFFF14113, 32'hF,        32'h0,        21, 32'hF,        32'hFFFFFFFF, 32'h0,        2,  1, 0};

        idle_in();
        u_if.flush_i     = 1'b0;
        u_if.out_ready_i = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_empty("reset");
        check("reset.f",   32'(u_if.f_o),       32'd0);
        check("reset.op1", u_if.op1_o,          32'd0);
        check("reset.op2", u_if.op2_o,          32'd0);
        check("reset.sd",  u_if.store_data_o,   32'd0);
        check("reset.rd_we", 32'(u_if.rd_we_o), 32'd0);

        // Back-to-back vectors with the ALU always ready: one per cycle,
        // each visible on the outputs the cycle after acceptance.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            #1;
            check({vecs[i].name, ".rs1_addr"}, 32'(u_if.rs1_addr_o), 32'(vecs[i].instr[19:15]));
            check({vecs[i].name, ".rs2_addr"}, 32'(u_if.rs2_addr_o), 32'(vecs[i].instr[24:20]));
            check({vecs[i].name, ".in_ready"}, 32'(u_if.in_ready_o), 32'd1);
            step();
            check_out(vecs[i].name, vecs[i]);
        end
        idle_in();
        step();
        check("drain.out_valid", 32'(u_if.out_valid_o), 32'd0);

        // Backpressure: A in MAIN, B in SKID, C held off.
        u_if.out_ready_i = 1'b0;
        drive(vecs[0]);
        step();
        check_out("bp.A_main", vecs[0]);
        check("bp.ready_after_A", 32'(u_if.in_ready_o), 32'd1);
        drive(vecs[1]);
        step();
        check_out("bp.A_hold1", vecs[0]);
        check("bp.ready_full", 32'(u_if.in_ready_o), 32'd0);
        drive(vecs[2]);
        step();
        check_out("bp.A_hold2", vecs[0]);
        check("bp.ready_still_full", 32'(u_if.in_ready_o), 32'd0);
        step();
        check_out("bp.A_hold3", vecs[0]);
        u_if.out_ready_i = 1'b1;
        step();
        check_out("bp.B", vecs[1]);
        check("bp.ready_reopen", 32'(u_if.in_ready_o), 32'd1);
        step();
        check_out("bp.C", vecs[2]);
        idle_in();
        step();
        check("bp.done", 32'(u_if.out_valid_o), 32'd0);

        // Flush with both entries full and an instruction offered.
        u_if.out_ready_i = 1'b0;
        drive(vecs[4]);
        step();
        drive(vecs[6]);
        step();
        drive(vecs[8]);
        u_if.flush_i = 1'b1;
        step();
        u_if.flush_i = 1'b0;
        idle_in();
        check_empty("flush_full");
        u_if.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("flush_full.no_ghost%0d", i), 32'(u_if.out_valid_o), 32'd0);
        end

        // Flush wins over an input handshake while only MAIN is valid.
        u_if.out_ready_i = 1'b0;
        drive(vecs[9]);
        step();
        drive(vecs[14]);
        u_if.flush_i = 1'b1;
        step();
        u_if.flush_i = 1'b0;
        idle_in();
        check_empty("flush_hs");
        u_if.out_ready_i = 1'b1;
        step();
        check("flush_hs.dropped", 32'(u_if.out_valid_o), 32'd0);

        // Post-flush recovery.
        drive(vecs[13]);
        step();
        check_out("post_flush", vecs[13]);
        idle_in();

        // Reset mid-operation clears data outputs too.
        u_if.out_ready_i = 1'b0;
        drive(vecs[2]);
        step();
        drive(vecs[1]);
        step();
        rst = 1'b1;
        idle_in();
        step();
        rst = 1'b0;
        check_empty("mid_reset");
        check("mid_reset.f",   32'(u_if.f_o),     32'd0);
        check("mid_reset.op1", u_if.op1_o,        32'd0);
        check("mid_reset.op2", u_if.op2_o,        32'd0);
        check("mid_reset.sd",  u_if.store_data_o, 32'd0);
        check("mid_reset.rd",  32'(u_if.rd_o),    32'd0);
        u_if.out_ready_i = 1'b1;
        step();
        check("mid_reset.no_ghost", 32'(u_if.out_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
